// File: rtl/tank_move_arbiter.sv
// Per-frame tank movement sequencer: decodes both players' keys, applies cooldown,
// and checks each move through one shared map read port. Optional macro TANK_WRAP_EN.
module tank_move_arbiter #(
  parameter int MAP_W         = 20,
  parameter int MAP_H         = 15,
  parameter int P1_TX0        = 1,
  parameter int P1_TY0        = 13,
  parameter int P2_TX0        = 18,
  parameter int P2_TY0        = 1,
  parameter int MOVE_COOLDOWN = 8
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_tick,
  input  logic [7:0] keycode1,
  input  logic [7:0] keycode2,
  output logic       map_rd_en,
  output logic [8:0] map_addr,
  input  logic [1:0] map_rd_data,
  output logic [9:0] Tank1X,
  output logic [9:0] Tank1Y,
  output logic [9:0] Tank2X,
  output logic [9:0] Tank2Y,
  output logic [1:0] tank1_dir,
  output logic [1:0] tank2_dir,
  output logic       busy
);
  localparam int         CDW  = $clog2(MOVE_COOLDOWN + 1);
  localparam logic [4:0] XMAX = 5'(MAP_W - 1);
  localparam logic [3:0] YMAX = 4'(MAP_H - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CHK_A, S_WAIT_A, S_EVAL_A, S_CHK_B, S_WAIT_B, S_EVAL_B
  } state_t;

  state_t                    state_q, state_d;
  logic [1:0][4:0]           tx_q, tx_d;
  logic [1:0][3:0]           ty_q, ty_d;
  logic [1:0][1:0]           dir_q, dir_d;
  logic [1:0][CDW-1:0]       cd_q, cd_d;
  logic [1:0][7:0]           key_q, key_d;
  logic                      first_q, first_d;
  logic                      rd_en_q, rd_en_d;
  logic [8:0]                addr_q, addr_d;
  logic [4:0]                ntx_q, ntx_d;
  logic [3:0]                nty_q, nty_d;
  logic                      pend_q, pend_d;

  // Index 0 is player 1; cur selects the tank owning the current CHK/WAIT/EVAL triple.
  logic       cur;
  logic       key_vld;
  logic [1:0] key_dir;
  logic [4:0] tgt_x;
  logic [3:0] tgt_y;
  logic       tgt_ok;
  logic [8:0] tgt_addr;

  always_comb begin
    cur = (state_q == S_CHK_B || state_q == S_WAIT_B || state_q == S_EVAL_B) ? ~first_q : first_q;
  end

  always_comb begin
    key_vld = 1'b1;
    key_dir = 2'b00;
    if (!cur) begin
      case (key_q[0])
        8'h04:   key_dir = 2'b10;
        8'h07:   key_dir = 2'b11;
        8'h16:   key_dir = 2'b01;
        8'h1A:   key_dir = 2'b00;
        default: key_vld = 1'b0;
      endcase
    end else begin
      case (key_q[1])
        8'h50:   key_dir = 2'b10;
        8'h4F:   key_dir = 2'b11;
        8'h51:   key_dir = 2'b01;
        8'h52:   key_dir = 2'b00;
        default: key_vld = 1'b0;
      endcase
    end
  end

  // Edge handling: reject (tgt_ok=0) or wrap to the opposite edge.
  always_comb begin
    tgt_x  = tx_q[cur];
    tgt_y  = ty_q[cur];
    tgt_ok = 1'b1;
    case (key_dir)
      2'b00: begin
        if (ty_q[cur] == 4'd0) begin
`ifdef TANK_WRAP_EN
          tgt_y = YMAX;
`else
          tgt_ok = 1'b0;
`endif
        end else tgt_y = ty_q[cur] - 4'd1;
      end
      2'b01: begin
        if (ty_q[cur] >= YMAX) begin
`ifdef TANK_WRAP_EN
          tgt_y = 4'd0;
`else
          tgt_ok = 1'b0;
`endif
        end else tgt_y = ty_q[cur] + 4'd1;
      end
      2'b10: begin
        if (tx_q[cur] == 5'd0) begin
`ifdef TANK_WRAP_EN
          tgt_x = XMAX;
`else
          tgt_ok = 1'b0;
`endif
        end else tgt_x = tx_q[cur] - 5'd1;
      end
      default: begin
        if (tx_q[cur] >= XMAX) begin
`ifdef TANK_WRAP_EN
          tgt_x = 5'd0;
`else
          tgt_ok = 1'b0;
`endif
        end else tgt_x = tx_q[cur] + 5'd1;
      end
    endcase
    tgt_addr = 9'(tgt_y) * 9'(MAP_W) + 9'(tgt_x);
  end

  always_comb begin
    state_d = state_q;
    tx_d    = tx_q;
    ty_d    = ty_q;
    dir_d   = dir_q;
    cd_d    = cd_q;
    key_d   = key_q;
    first_d = first_q;
    rd_en_d = 1'b0;
    addr_d  = addr_q;
    ntx_d   = ntx_q;
    nty_d   = nty_q;
    pend_d  = pend_q;
    case (state_q)
      S_IDLE: begin
        if (frame_tick) begin
          key_d   = {keycode2, keycode1};
          state_d = S_CHK_A;
        end
      end
      S_CHK_A, S_CHK_B: begin
        pend_d = 1'b0;
        if (cd_q[cur] != '0) begin
          cd_d[cur] = cd_q[cur] - 1'b1;
        end else if (key_vld) begin
          dir_d[cur] = key_dir;
          if (tgt_ok) begin
            rd_en_d = 1'b1;
            addr_d  = tgt_addr;
            ntx_d   = tgt_x;
            nty_d   = tgt_y;
            pend_d  = 1'b1;
          end
        end
        state_d = (state_q == S_CHK_A) ? S_WAIT_A : S_WAIT_B;
      end
      S_WAIT_A: state_d = S_EVAL_A;
      S_WAIT_B: state_d = S_EVAL_B;
      default: begin
        // Other tank's tile is read live, so a first-served move is already visible here.
        if (pend_q && map_rd_data == 2'b00 &&
            !(ntx_q == tx_q[~cur] && nty_q == ty_q[~cur])) begin
          tx_d[cur] = ntx_q;
          ty_d[cur] = nty_q;
          cd_d[cur] = CDW'(MOVE_COOLDOWN);
        end
        pend_d = 1'b0;
        if (state_q == S_EVAL_A) begin
          state_d = S_CHK_B;
        end else begin
          state_d = S_IDLE;
          first_d = ~first_q;
        end
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
      tx_q    <= {5'(P2_TX0), 5'(P1_TX0)};
      ty_q    <= {4'(P2_TY0), 4'(P1_TY0)};
      dir_q   <= {2'b01, 2'b00};
      cd_q    <= '0;
      key_q   <= '0;
      first_q <= 1'b0;
      rd_en_q <= 1'b0;
      addr_q  <= '0;
      ntx_q   <= '0;
      nty_q   <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      ty_q    <= ty_d;
      dir_q   <= dir_d;
      cd_q    <= cd_d;
      key_q   <= key_d;
      first_q <= first_d;
      rd_en_q <= rd_en_d;
      addr_q  <= addr_d;
      ntx_q   <= ntx_d;
      nty_q   <= nty_d;
      pend_q  <= pend_d;
    end
  end

  assign map_rd_en = rd_en_q;
  assign map_addr  = addr_q;
  assign Tank1X    = {tx_q[0], 5'b0};
  assign Tank1Y    = {1'b0, ty_q[0], 5'b0};
  assign Tank2X    = {tx_q[1], 5'b0};
  assign Tank2Y    = {1'b0, ty_q[1], 5'b0};
  assign tank1_dir = dir_q[0];
  assign tank2_dir = dir_q[1];
  assign busy      = (state_q != S_IDLE);
endmodule
